serial_rx_ack: RTL and testbench

//  Receiving end of the lab's 4-phase rdy/ack bit-serial link. Samples one bit per rdy/ack

---
 rtl/serial_link_pkg.sv | 20 ++
 rtl/serial_rx_ack_if.sv | 24 ++
 rtl/hs_timeout_cnt.sv | 26 ++
 rtl/serial_rx_ack.sv | 122 ++++++++++++
 tb/tb_serial_rx_ack.sv | 223 ++++++++++++++++++++++
 5 files changed

// File: rtl/serial_link_pkg.sv
// Shared definitions for both ends of the 4-phase rdy/ack bit-serial link.
// Sender and receiver use the same state encodings and frame layout (LSB first, parity last).
package serial_link_pkg;

    typedef enum logic [1:0] {
        ST_WAIT  = 2'b00,
        ST_ACK   = 2'b01,
        ST_CHECK = 2'b10,
        ST_ERR   = 2'b11
    } link_state_t;

    localparam int DEF_DATA_W  = 3;
    localparam int DEF_FRAME_W = DEF_DATA_W + 1;

    // A frame carries the data bits followed by one parity bit.
    function automatic int frame_w(input int data_w);
        return data_w + 1;
    endfunction

endpackage

// File: rtl/serial_rx_ack_if.sv
// Receiver-side view of the rdy/ack serial link plus the decoded-word outputs.
// The master modport is the sender/bench side and the slave modport is the receiver.
interface serial_rx_ack_if #(
    parameter int DATA_W = 3
);
    logic              rdyi;
    logic              datai;
    logic              acko;
    logic              shiftr;
    logic [DATA_W-1:0] dataout;
    logic              valid;
    logic              error;
    logic [1:0]        yr;

    modport master (
        output rdyi, datai,
        input  acko, shiftr, dataout, valid, error, yr
    );

    modport slave (
        input  rdyi, datai,
        output acko, shiftr, dataout, valid, error, yr
    );
endinterface

// File: rtl/hs_timeout_cnt.sv
// Handshake wait counter. It clears, counts while enabled and saturates at TIMEOUT-1.
// o_expire is asserted in the TIMEOUT-th enabled cycle that follows a clear.
module hs_timeout_cnt #(
    parameter int TIMEOUT = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic i_clr,
    input  logic i_en,
    output logic o_expire
);
    localparam int W = $clog2(TIMEOUT);

    logic [W-1:0] r_cnt;

    assign o_expire = (r_cnt == W'(TIMEOUT - 1));

    always_ff @(posedge clk) begin
        if (reset || i_clr) begin
            r_cnt <= '0;
        end else if (i_en && !o_expire) begin
            r_cnt <= r_cnt + W'(1);
        end
    end

endmodule

// File: rtl/serial_rx_ack.sv
// Receiving end of the 4-phase rdy/ack bit-serial link. It samples one bit per handshake and
// assembles DATA_W data bits plus parity (LSB first). It reports each frame with a valid pulse.
module serial_rx_ack
    import serial_link_pkg::*;
#(
    parameter int DATA_W     = DEF_DATA_W,
    parameter bit ODD_PARITY = 1'b1,
    parameter int TIMEOUT    = 16
) (
    input  logic           clk,
    input  logic           reset,
    serial_rx_ack_if.slave rx
);
    localparam int FRAME_W = frame_w(DATA_W);
    localparam int CNT_W   = $clog2(DATA_W + 2);

    link_state_t        r_state;
    link_state_t        w_next;
    logic [FRAME_W-1:0] r_shreg;
    logic [CNT_W-1:0]   r_bit_cnt;
    logic [DATA_W-1:0]  r_dataout;
    logic               r_error;

    logic w_sample;
    logic w_to_check;
    logic w_to_err;
    logic w_expire;
    logic w_frame_done;
    logic w_parity_bad;

    assign w_frame_done = (r_bit_cnt == CNT_W'(FRAME_W));
    assign w_parity_bad = ((^r_shreg) != ODD_PARITY);

    hs_timeout_cnt #(
        .TIMEOUT (TIMEOUT)
    ) u_ack_timer (
        .clk      (clk),
        .reset    (reset),
        .i_clr    (r_state != ST_ACK),
        .i_en     (r_state == ST_ACK),
        .o_expire (w_expire)
    );

    // NOTE: sequential state uses non-blocking assignments only, so every flop reads pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_WAIT;
        end else begin
            r_state <= w_next;
        end
    end

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        w_next     = r_state;
        w_sample   = 1'b0;
        w_to_check = 1'b0;
        w_to_err   = 1'b0;
        unique case (r_state)
            ST_WAIT: begin
                if (rx.rdyi) begin
                    w_sample = 1'b1;
                    w_next   = ST_ACK;
                end
            end
            ST_ACK: begin
                // A falling rdyi takes priority over a timeout that expires in the same cycle.
                if (!rx.rdyi) begin
                    if (w_frame_done) begin
                        w_to_check = 1'b1;
                        w_next     = ST_CHECK;
                    end else begin
                        w_next = ST_WAIT;
                    end
                end else if (w_expire) begin
                    w_to_err = 1'b1;
                    w_next   = ST_ERR;
                end
            end
            ST_CHECK: w_next = ST_WAIT;
            ST_ERR: begin
                if (!rx.rdyi) begin
                    w_next = ST_WAIT;
                end
            end
            default: w_next = ST_WAIT;
        endcase
    end

    // NOTE: the shift register is reset too, so the bits of a discarded partial frame cannot reach the parity check.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_shreg   <= '0;
            r_bit_cnt <= '0;
            r_dataout <= '0;
            r_error   <= 1'b0;
        end else begin
            if (w_sample) begin
                r_shreg   <= {rx.datai, r_shreg[FRAME_W-1:1]};
                r_bit_cnt <= r_bit_cnt + CNT_W'(1);
            end
            if (w_to_check) begin
                r_dataout <= r_shreg[DATA_W-1:0];
                r_error   <= w_parity_bad;
                r_bit_cnt <= '0;
            end
            if (w_to_err) begin
                r_error   <= 1'b1;
                r_bit_cnt <= '0;
                r_shreg   <= '0;
            end
        end
    end

    assign rx.acko    = (r_state == ST_ACK);
    assign rx.shiftr  = w_sample && !reset;
    assign rx.valid   = (r_state == ST_CHECK);
    assign rx.dataout = r_dataout;
    assign rx.error   = r_error;
    assign rx.yr      = r_state;

endmodule

// File: tb/tb_serial_rx_ack.sv
// Self-checking bench for serial_rx_ack. It applies table vectors, hand-written corner sequences
// and random frames, and compares the results against a per-frame parity model.
module tb_serial_rx_ack;
    localparam int DATA_W  = 3;
    localparam bit ODD     = 1'b1;
    localparam int TIMEOUT = 16;

    typedef struct {
        logic [2:0] data;
        logic       par;
        logic [2:0] exp_data;
        logic       exp_err;
    } vec_t;

    logic clk = 1'b0;
    logic reset;
    int   total = 0;
    int   bad   = 0;

    int n_shift = 0, n_ack_rise = 0, n_ack_cyc = 0, n_valid = 0, n_double = 0;
    logic prev_ack = 1'b0, prev_valid = 1'b0;
    logic [3:0] rx_q[$];
    logic [3:0] exp_q[$];
    vec_t vecs[7];

    serial_rx_ack_if #(.DATA_W(DATA_W)) bus ();

    serial_rx_ack #(
        .DATA_W     (DATA_W),
        .ODD_PARITY (ODD),
        .TIMEOUT    (TIMEOUT)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .rx    (bus)
    );

    always #10 clk = ~clk;

    // The monitor samples mid-cycle and records every word presented with valid as {error, dataout}.
    always @(negedge clk) begin
        if (bus.shiftr) n_shift++;
        if (bus.acko) n_ack_cyc++;
        if (bus.acko && !prev_ack) n_ack_rise++;
        prev_ack = bus.acko;
        if (bus.valid) begin
            n_valid++;
            if (prev_valid) n_double++;
            rx_q.push_back({bus.error, bus.dataout});
        end
        prev_valid = bus.valid;
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic wait_acko(input logic lvl);
        int k;
        k = 0;
        while (bus.acko !== lvl && k < 40) begin
            tick();
            k++;
        end
        if (bus.acko !== lvl) begin
            total++;
            bad++;
            $display("FAIL acko_wait: acko=%b, expected %b within 40 cycles", bus.acko, lvl);
        end
    endtask

    task automatic send_bit(input logic b, input int gap, input int hold);
        repeat (gap) tick();
        bus.rdyi  = 1'b1;
        bus.datai = b;
        wait_acko(1'b1);
        repeat (hold) tick();
        bus.rdyi = 1'b0;
        wait_acko(1'b0);
    endtask

    task automatic send_frame(input logic [2:0] d, input logic p, input int gap0, input bit rnd);
        int gap, hold;
        for (int i = 0; i <= DATA_W; i++) begin
            gap  = (i == 0) ? gap0 : 0;
            hold = 0;
            if (rnd) begin
                gap  = $urandom_range(0, 2);
                hold = $urandom_range(0, 3);
            end
            send_bit((i < DATA_W) ? d[i] : p, gap, hold);
        end
    endtask

    initial begin
        int nv, s0, a0, v0, c0;
        logic [2:0] d;
        logic       p;

        vecs[0] = '{3'b001, 1'b0, 3'b001, 1'b0};
        vecs[1] = '{3'b011, 1'b0, 3'b011, 1'b1};
        vecs[2] = '{3'b010, 1'b0, 3'b010, 1'b0};
        vecs[3] = '{3'b101, 1'b1, 3'b101, 1'b0};
        vecs[4] = '{3'b111, 1'b1, 3'b111, 1'b1};
        vecs[5] = '{3'b000, 1'b1, 3'b000, 1'b0};
        vecs[6] = '{3'b000, 1'b0, 3'b000, 1'b1};

        // Reset is held with rdyi high, and reset must win over it.
        reset     = 1'b1;
        bus.rdyi  = 1'b1;
        bus.datai = 1'b1;
        repeat (5) tick();
        check("rst_acko", bus.acko, 0);
        check("rst_yr", bus.yr, 0);
        check("rst_dataout", bus.dataout, 0);
        check("rst_error", bus.error, 0);
        check("rst_valid", bus.valid, 0);
        check("rst_shiftr", bus.shiftr, 0);
        bus.rdyi = 1'b0;
        tick();
        reset = 1'b0;
        tick();

        // The good frame 1,0,0 with parity 0 must produce 4 shiftr pulses, 4 acko pulses and 1 valid.
        s0 = n_shift; a0 = n_ack_rise; v0 = n_valid;
        send_frame(3'b001, 1'b0, 0, 0);
        tick();
        check("good_shiftr_pulses", n_shift - s0, 4);
        check("good_acko_pulses", n_ack_rise - a0, 4);
        check("good_valid_pulses", n_valid - v0, 1);
        check("good_dataout", bus.dataout, 3'b001);
        check("good_error", bus.error, 0);
        check("good_valid_low_after", bus.valid, 0);

        for (int i = 0; i < 7; i++) begin
            nv = rx_q.size();
            send_frame(vecs[i].data, vecs[i].par, 0, 0);
            tick();
            check("tbl_count", rx_q.size(), nv + 1);
            if (rx_q.size() > nv) check("tbl_word", rx_q[nv], {vecs[i].exp_err, vecs[i].exp_data});
            check("tbl_error_held", bus.error, vecs[i].exp_err);
            check("tbl_dataout_held", bus.dataout, vecs[i].exp_data);
        end

        // Timeout: rdyi is held high on the third bit for 40 cycles.
        send_bit(1'b1, 0, 0);
        send_bit(1'b0, 0, 0);
        v0 = n_valid; c0 = n_ack_cyc;
        bus.rdyi  = 1'b1;
        bus.datai = 1'b1;
        repeat (40) tick();
        check("to_acko_cycles", n_ack_cyc - c0, TIMEOUT);
        check("to_yr", bus.yr, 2'b11);
        check("to_error", bus.error, 1);
        check("to_no_valid", n_valid - v0, 0);
        check("to_acko_low", bus.acko, 0);
        bus.rdyi = 1'b0;
        tick();
        check("to_yr_wait", bus.yr, 2'b00);
        nv = rx_q.size();
        send_frame(3'b100, 1'b0, 0, 0);
        tick();
        check("to_recover_count", rx_q.size(), nv + 1);
        check("to_recover_word", bus.dataout, 3'b100);
        check("to_recover_error", bus.error, 0);

        // Reset is pulsed mid-frame after two bits, and the partial frame is discarded.
        send_bit(1'b0, 0, 0);
        send_bit(1'b1, 0, 0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("midrst_yr", bus.yr, 0);
        check("midrst_bit_cnt", dut.r_bit_cnt, 0);
        check("midrst_dataout", bus.dataout, 0);
        check("midrst_error", bus.error, 0);
        nv = rx_q.size();
        send_frame(3'b101, 1'b1, 0, 0);
        tick();
        check("midrst_count", rx_q.size(), nv + 1);
        check("midrst_word", bus.dataout, 3'b101);
        check("midrst_frame_error", bus.error, 0);

        // Back-to-back frames: rdyi is raised again in the cycle after CHECK.
        nv = rx_q.size();
        send_frame(3'b011, 1'b1, 0, 0);
        send_frame(3'b100, 1'b0, 1, 0);
        tick();
        check("b2b_count", rx_q.size(), nv + 2);
        if (rx_q.size() >= nv + 2) begin
            check("b2b_first", rx_q[nv], 4'b0011);
            check("b2b_second", rx_q[nv+1], 4'b0100);
        end

        // Random frames with random gaps and hold times. error = ((^data ^ parity) != ODD).
        rx_q.delete();
        for (int f = 0; f < 24; f++) begin
            d = 3'($urandom_range(0, 7));
            p = 1'($urandom_range(0, 1));
            exp_q.push_back({(((^d) ^ p) != ODD), d});
            send_frame(d, p, 0, 1);
        end
        repeat (2) tick();
        check("rnd_count", rx_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size(); i++) begin
            if (i < rx_q.size()) check("rnd_word", rx_q[i], exp_q[i]);
        end
        check("valid_single_cycle", n_double, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
